// File: rtl/zynet_regs_pkg.sv
// zynet_regs_pkg
// Shared definitions for the zyNet AXI4-Lite register slice:
//   - byte offsets of every register in the map (decode uses addr[4:2])
//   - AXI response codes
//   - write/read channel FSM state encodings
//   - byte-strobe merge helper for the read/write configuration registers
package zynet_regs_pkg;

    localparam logic [4:0] ADDR_WEIGHT = 5'h00;
    localparam logic [4:0] ADDR_BIAS   = 5'h04;
    localparam logic [4:0] ADDR_RESULT = 5'h08;
    localparam logic [4:0] ADDR_LAYER  = 5'h0C;
    localparam logic [4:0] ADDR_NEURON = 5'h10;
    localparam logic [4:0] ADDR_NOUT   = 5'h14;
    localparam logic [4:0] ADDR_STATUS = 5'h18;
    localparam logic [4:0] ADDR_SRST   = 5'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? wdat[i*8 +: 8] : cur[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/zynet_axil_irq.sv
// zynet_axil_irq
// Result latch and level interrupt for the zyNet register slice.
//   clk, rst_n    : clock, asynchronous active-low reset
//   result_in     : network output, zero-extended into result
//   result_valid  : one-cycle pulse, latches result_in and sets intr
//   clear         : completed read of the result register, clears intr
//   result        : latched result (32 bits)
//   intr          : level interrupt, high until the result is read
// A result arriving in the same cycle as the clearing read wins, so no
// result can be lost between software reading and the core producing.
module zynet_axil_irq
    import zynet_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  result_valid,
    input  logic                  clear,
    output logic [31:0]           result,
    output logic                  intr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= 32'd0;
            intr   <= 1'b0;
        end else if (result_valid) begin
            result <= 32'(result_in);
            intr   <= 1'b1;
        end else if (clear) begin
            intr   <= 1'b0;
        end
    end

endmodule

// File: rtl/zynet_axil_slave.sv
// zynet_axil_slave
// AXI4-Lite responder and register file in front of the zyNet core.
// Ports:
//   s_axi_*          : AXI4-Lite slave (clock, async active-low reset, AW/W/B/AR/R)
//   weight_valid     : one-cycle strobe, weight_value holds a new weight
//   bias_valid       : one-cycle strobe, weight_value holds a new bias
//   weight_value     : last written weight/bias word
//   layer_num        : configured layer (1..NUM_LAYERS accepted)
//   neuron_num       : configured neuron
//   result_in/valid  : network output and its one-cycle qualifier
//   neuron_out_data  : per-neuron debug output
//   neuron_out_rd    : pop strobe, pulses in the cycle a read of 0x14 is accepted
//   soft_reset       : core soft reset, active-high, 1 out of reset
//   intr             : result-ready level interrupt
// Build option: define ZYNET_CFG_COUNT_EN to add a 16-bit weight/bias load
// counter readable at 0x00; otherwise 0x00 reads as 0.
module zynet_axil_slave
    import zynet_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_LAYERS = 3
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  weight_valid,
    output logic                  bias_valid,
    output logic [31:0]           weight_value,
    output logic [31:0]           layer_num,
    output logic [31:0]           neuron_num,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  result_valid,
    input  logic [DATA_WIDTH-1:0] neuron_out_data,
    output logic                  neuron_out_rd,
    output logic                  soft_reset,
    output logic                  intr
);

    wr_state_t   wr_state, wr_next;
    rd_state_t   rd_state, rd_next;

    logic        wr_fire;
    logic        rd_fire;
    logic [4:0]  wr_off;
    logic [4:0]  rd_off;
    logic [31:0] layer_merged;
    logic [31:0] neuron_merged;
    logic        layer_bad;
    logic        wr_err;
    logic [31:0] rd_mux;
    logic [31:0] weight_rd;
    logic        rd_is_result;
    logic        irq_clear;
    logic [31:0] result_reg;

    // Byte-lane bits of the addresses carry no information.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign wr_off = {s_axi_awaddr[4:2], 2'b00};
    assign rd_off = {s_axi_araddr[4:2], 2'b00};

    // ---------------- write channel ----------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    // AW and W are only taken together; either alone waits with ready low.
    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    s_axi_awready = 1'b1;
                    s_axi_wready  = 1'b1;
                    wr_next       = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    assign wr_fire      = s_axi_awready;
    assign s_axi_bvalid = (wr_state == WR_RESP);

    // Layer legality is judged on the value after the strobe merge.
    always_comb begin
        layer_merged  = strb_merge(layer_num, s_axi_wdata, s_axi_wstrb);
        neuron_merged = strb_merge(neuron_num, s_axi_wdata, s_axi_wstrb);
        layer_bad     = (layer_merged == 32'd0) || (layer_merged > 32'(NUM_LAYERS));
        case (wr_off)
            ADDR_RESULT, ADDR_NOUT, ADDR_STATUS: wr_err = 1'b1;
            ADDR_LAYER:                          wr_err = layer_bad;
            default:                             wr_err = 1'b0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_bresp  <= RESP_OKAY;
            weight_valid <= 1'b0;
            bias_valid   <= 1'b0;
            weight_value <= 32'd0;
            layer_num    <= 32'd0;
            neuron_num   <= 32'd0;
            soft_reset   <= 1'b1;
        end else begin
            weight_valid <= 1'b0;
            bias_valid   <= 1'b0;
            if (wr_fire) begin
                s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (!wr_err) begin
                    case (wr_off)
                        ADDR_WEIGHT: begin
                            weight_value <= s_axi_wdata;
                            weight_valid <= 1'b1;
                        end
                        ADDR_BIAS: begin
                            weight_value <= s_axi_wdata;
                            bias_valid   <= 1'b1;
                        end
                        ADDR_LAYER:  layer_num  <= layer_merged;
                        ADDR_NEURON: neuron_num <= neuron_merged;
                        ADDR_SRST: begin
                            if (s_axi_wstrb[0]) begin
                                soft_reset <= s_axi_wdata[0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef ZYNET_CFG_COUNT_EN
    logic [15:0] load_count;
    logic        soft_reset_d;

    // soft_reset_d resets to 1 so leaving reset is not seen as a rising edge.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            load_count   <= 16'd0;
            soft_reset_d <= 1'b1;
        end else begin
            soft_reset_d <= soft_reset;
            if (soft_reset && !soft_reset_d) begin
                load_count <= 16'd0;
            end else if (weight_valid || bias_valid) begin
                load_count <= load_count + 16'd1;
            end
        end
    end

    assign weight_rd = {16'd0, load_count};
`else
    assign weight_rd = 32'd0;
`endif

    // ---------------- read channel ----------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (s_axi_arvalid) begin
                    s_axi_arready = 1'b1;
                    rd_next       = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    rd_next = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    assign rd_fire       = s_axi_arready;
    assign s_axi_rvalid  = (rd_state == RD_DATA);
    assign neuron_out_rd = rd_fire && (rd_off == ADDR_NOUT);

    always_comb begin
        case (rd_off)
            ADDR_WEIGHT: rd_mux = weight_rd;
            ADDR_RESULT: rd_mux = result_reg;
            ADDR_LAYER:  rd_mux = layer_num;
            ADDR_NEURON: rd_mux = neuron_num;
            ADDR_NOUT:   rd_mux = 32'(neuron_out_data);
            ADDR_STATUS: rd_mux = {30'd0, soft_reset, intr};
            ADDR_SRST:   rd_mux = {31'd0, soft_reset};
            default:     rd_mux = 32'd0;
        endcase
    end

    // rdata is captured at the AR handshake and only changes on the next one,
    // so it stays stable while the initiator stalls R.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rdata  <= 32'd0;
            s_axi_rresp  <= RESP_OKAY;
            rd_is_result <= 1'b0;
        end else if (rd_fire) begin
            s_axi_rdata  <= rd_mux;
            s_axi_rresp  <= RESP_OKAY;
            rd_is_result <= (rd_off == ADDR_RESULT);
        end
    end

    // Interrupt is cleared only once software has actually taken the result.
    assign irq_clear = s_axi_rvalid && s_axi_rready && rd_is_result;

    zynet_axil_irq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_irq (
        .clk          (s_axi_aclk),
        .rst_n        (s_axi_aresetn),
        .result_in    (result_in),
        .result_valid (result_valid),
        .clear        (irq_clear),
        .result       (result_reg),
        .intr         (intr)
    );

endmodule

// File: tb/tb_zynet_axil_slave.sv
// tb_zynet_axil_slave
// Directed self-checking bench for zynet_axil_slave. Inputs are driven on the
// falling clock edge and outputs are sampled away from the rising edge.
module tb_zynet_axil_slave;

    logic        clk;
    logic        aresetn;
    logic [4:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        weight_valid;
    logic        bias_valid;
    logic [31:0] weight_value;
    logic [31:0] layer_num;
    logic [31:0] neuron_num;
    logic [15:0] result_in;
    logic        result_valid;
    logic [15:0] neuron_out_data;
    logic        neuron_out_rd;
    logic        soft_reset;
    logic        intr;

    int tests;
    int fails;
    int wv_cnt;
    int bv_cnt;
    int nrd_cnt;

    zynet_axil_slave dut (
        .s_axi_aclk      (clk),
        .s_axi_aresetn   (aresetn),
        .s_axi_awaddr    (awaddr),
        .s_axi_awvalid   (awvalid),
        .s_axi_awready   (awready),
        .s_axi_wdata     (wdata),
        .s_axi_wstrb     (wstrb),
        .s_axi_wvalid    (wvalid),
        .s_axi_wready    (wready),
        .s_axi_bresp     (bresp),
        .s_axi_bvalid    (bvalid),
        .s_axi_bready    (bready),
        .s_axi_araddr    (araddr),
        .s_axi_arvalid   (arvalid),
        .s_axi_arready   (arready),
        .s_axi_rdata     (rdata),
        .s_axi_rresp     (rresp),
        .s_axi_rvalid    (rvalid),
        .s_axi_rready    (rready),
        .weight_valid    (weight_valid),
        .bias_valid      (bias_valid),
        .weight_value    (weight_value),
        .layer_num       (layer_num),
        .neuron_num      (neuron_num),
        .result_in       (result_in),
        .result_valid    (result_valid),
        .neuron_out_data (neuron_out_data),
        .neuron_out_rd   (neuron_out_rd),
        .soft_reset      (soft_reset),
        .intr            (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters sampled mid-low-phase, when all inputs are settled.
    always begin
        @(negedge clk);
        #2;
        if (weight_valid)  wv_cnt++;
        if (bias_valid)    bv_cnt++;
        if (neuron_out_rd) nrd_cnt++;
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        #1;
        while (!awready && n < 50) begin @(negedge clk); #1; n++; end
        if (!awready) begin
            tests++; fails++;
            $display("FAIL aw_timeout got awready=%b required 1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        #1;
        while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (!bvalid) begin
            tests++; fails++;
            $display("FAIL b_timeout got bvalid=%b required 1", bvalid);
        end
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        #1;
        while (!arready && n < 50) begin @(negedge clk); #1; n++; end
        if (!arready) begin
            tests++; fails++;
            $display("FAIL ar_timeout got arready=%b required 1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        #1;
        while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (!rvalid) begin
            tests++; fails++;
            $display("FAIL r_timeout got rvalid=%b required 1", rvalid);
        end
        d = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({soft_reset, intr, bvalid, rvalid, weight_valid, bias_valid, neuron_out_rd} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_ctrl got %b required 1000000",
                     {soft_reset, intr, bvalid, rvalid, weight_valid, bias_valid, neuron_out_rd});
        end
        tests++;
        if ({weight_value, layer_num, neuron_num} !== 96'd0) begin
            fails++;
            $display("FAIL reset_regs got %h %h %h required 0 0 0", weight_value, layer_num, neuron_num);
        end
        aresetn = 1'b1;
        @(negedge clk);
        axi_read(5'h1C, d, r);
        tests++;
        if (d !== 32'd1 || r !== 2'b00) begin
            fails++;
            $display("FAIL read_srst got %h/%b required 00000001/00", d, r);
        end
        axi_write(5'h1C, 32'd0, 4'hF, r);
        tests++;
        if (r !== 2'b00 || soft_reset !== 1'b0) begin
            fails++;
            $display("FAIL clear_srst got resp=%b soft_reset=%b required 00/0", r, soft_reset);
        end
        axi_read(5'h18, d, r);
        tests++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL status_idle got %h required 00000000", d);
        end
    endtask

    task automatic test_config_write();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_cnt;
        @(negedge clk);
        axi_write(5'h0C, 32'd2, 4'hF, r);
        tests++;
        if (r !== 2'b00 || layer_num !== 32'd2) begin
            fails++;
            $display("FAIL layer_wr got resp=%b layer=%h required 00/2", r, layer_num);
        end
        axi_write(5'h10, 32'd5, 4'hF, r);
        tests++;
        if (r !== 2'b00 || neuron_num !== 32'd5) begin
            fails++;
            $display("FAIL neuron_wr got resp=%b neuron=%h required 00/5", r, neuron_num);
        end
        wv_cnt = 0; bv_cnt = 0;
        axi_write(5'h00, 32'h1234, 4'hF, r);
        tests++;
        if (weight_value !== 32'h1234 || wv_cnt !== 1 || bv_cnt !== 0) begin
            fails++;
            $display("FAIL weight_wr got value=%h wv=%0d bv=%0d required 1234 1 0", weight_value, wv_cnt, bv_cnt);
        end
        wv_cnt = 0; bv_cnt = 0;
        axi_write(5'h04, 32'hBEEF, 4'h0, r);
        tests++;
        if (weight_value !== 32'hBEEF || wv_cnt !== 0 || bv_cnt !== 1) begin
            fails++;
            $display("FAIL bias_wr got value=%h wv=%0d bv=%0d required beef 0 1", weight_value, wv_cnt, bv_cnt);
        end
        axi_read(5'h0C, d, r);
        tests++;
        if (d !== 32'd2 || r !== 2'b00) begin
            fails++;
            $display("FAIL layer_rd got %h/%b required 00000002/00", d, r);
        end
`ifdef ZYNET_CFG_COUNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        axi_read(5'h00, d, r);
        tests++;
        if (d !== exp_cnt || r !== 2'b00) begin
            fails++;
            $display("FAIL weight_rd got %h/%b required %h/00", d, r, exp_cnt);
        end
        axi_read(5'h04, d, r);
        tests++;
        if (d !== 32'd0 || r !== 2'b00) begin
            fails++;
            $display("FAIL bias_rd got %h/%b required 00000000/00", d, r);
        end
        axi_write(5'h10, 32'hAABBCCDD, 4'b0010, r);
        tests++;
        if (neuron_num !== 32'h0000CC05) begin
            fails++;
            $display("FAIL neuron_strb got %h required 0000cc05", neuron_num);
        end
    endtask

    task automatic test_stall();
        int bad;
        @(negedge clk);
        awaddr = 5'h10; wdata = 32'd7; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        bad = 0;
        repeat (3) begin
            #1;
            if (awready || wready) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL aw_wait got %0d early ready cycles required 0", bad);
        end
        wvalid = 1'b1;
        #1;
        tests++;
        if ({awready, wready} !== 2'b11) begin
            fails++;
            $display("FAIL aw_accept got %b required 11", {awready, wready});
        end
        @(negedge clk);
        wdata = 32'd9;
        bad = 0;
        #1;
        repeat (4) begin
            if (!bvalid || awready) bad++;
            @(negedge clk);
            #1;
        end
        tests++;
        if (bad !== 0 || neuron_num !== 32'd7) begin
            fails++;
            $display("FAIL b_hold got bad=%0d neuron=%h required 0/7", bad, neuron_num);
        end
        bready = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (awready !== 1'b1) begin
            fails++;
            $display("FAIL second_accept got awready=%b required 1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        tests++;
        if (bvalid !== 1'b1 || neuron_num !== 32'd9) begin
            fails++;
            $display("FAIL second_write got bvalid=%b neuron=%h required 1/9", bvalid, neuron_num);
        end
        @(negedge clk);
        bready = 1'b0;
        #1;
        tests++;
        if (bvalid !== 1'b0) begin
            fails++;
            $display("FAIL b_release got bvalid=%b required 0", bvalid);
        end
    endtask

    task automatic test_result_irq();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        @(negedge clk);
        result_in = 16'h0001; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        tests++;
        if (intr !== 1'b1) begin
            fails++;
            $display("FAIL intr_set got %b required 1", intr);
        end
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h1 || intr !== 1'b0) begin
            fails++;
            $display("FAIL result_rd got %h intr=%b required 00000001/0", d, intr);
        end
        // coincident set and clear
        result_in = 16'h0022; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        araddr = 5'h08; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        #1;
        while (!arready && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h22) begin
            fails++;
            $display("FAIL stall_rd got rvalid=%b rdata=%h required 1/00000022", rvalid, rdata);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h22) begin
            fails++;
            $display("FAIL rdata_hold got rvalid=%b rdata=%h required 1/00000022", rvalid, rdata);
        end
        rready = 1'b1; result_in = 16'h0033; result_valid = 1'b1;
        @(negedge clk);
        rready = 1'b0; result_valid = 1'b0;
        tests++;
        if (intr !== 1'b1 || rvalid !== 1'b0) begin
            fails++;
            $display("FAIL set_wins got intr=%b rvalid=%b required 1/0", intr, rvalid);
        end
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h33 || intr !== 1'b0) begin
            fails++;
            $display("FAIL result_new got %h intr=%b required 00000033/0", d, intr);
        end
        // overwrite while pending; status read must not clear
        result_in = 16'h0044; result_valid = 1'b1;
        @(negedge clk);
        result_in = 16'h0055;
        @(negedge clk);
        result_valid = 1'b0;
        axi_read(5'h18, d, r);
        tests++;
        if (d !== 32'h1 || intr !== 1'b1) begin
            fails++;
            $display("FAIL status_intr got %h intr=%b required 00000001/1", d, intr);
        end
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h55 || intr !== 1'b0) begin
            fails++;
            $display("FAIL overwrite got %h intr=%b required 00000055/0", d, intr);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] r;
        @(negedge clk);
        axi_write(5'h0C, 32'd4, 4'hF, r);
        tests++;
        if (r !== 2'b10 || layer_num !== 32'd2) begin
            fails++;
            $display("FAIL layer_big got resp=%b layer=%h required 10/2", r, layer_num);
        end
        axi_write(5'h0C, 32'd0, 4'hF, r);
        tests++;
        if (r !== 2'b10 || layer_num !== 32'd2) begin
            fails++;
            $display("FAIL layer_zero got resp=%b layer=%h required 10/2", r, layer_num);
        end
        axi_write(5'h0C, 32'd3, 4'hF, r);
        tests++;
        if (r !== 2'b00 || layer_num !== 32'd3) begin
            fails++;
            $display("FAIL layer_max got resp=%b layer=%h required 00/3", r, layer_num);
        end
        axi_write(5'h08, 32'hFFFF, 4'hF, r);
        tests++;
        if (r !== 2'b10) begin
            fails++;
            $display("FAIL wr_result got resp=%b required 10", r);
        end
        axi_write(5'h14, 32'h1, 4'hF, r);
        tests++;
        if (r !== 2'b10) begin
            fails++;
            $display("FAIL wr_nout got resp=%b required 10", r);
        end
        axi_write(5'h1A, 32'h1, 4'hF, r);
        tests++;
        if (r !== 2'b10 || soft_reset !== 1'b0) begin
            fails++;
            $display("FAIL wr_status got resp=%b soft_reset=%b required 10/0", r, soft_reset);
        end
    endtask

    task automatic test_neuron_out();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        neuron_out_data = 16'h00AB;
        nrd_cnt = 0;
        axi_read(5'h14, d, r);
        tests++;
        if (d !== 32'hAB || r !== 2'b00 || nrd_cnt !== 1) begin
            fails++;
            $display("FAIL nout_rd got %h/%b pops=%0d required 000000ab/00 1", d, r, nrd_cnt);
        end
        axi_read(5'h10, d, r);
        tests++;
        if (nrd_cnt !== 1 || d !== 32'd9) begin
            fails++;
            $display("FAIL nout_nopop got pops=%0d neuron=%h required 1/9", nrd_cnt, d);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        @(negedge clk);
        araddr = 5'h10; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        #1;
        while (!arready && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        tests++;
        if (rvalid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset got rvalid=%b required 1", rvalid);
        end
        #2;
        aresetn = 1'b0;
        #1;
        tests++;
        if (rvalid !== 1'b0 || soft_reset !== 1'b1 || layer_num !== 32'd0) begin
            fails++;
            $display("FAIL async_reset got rvalid=%b soft_reset=%b layer=%h required 0/1/0",
                     rvalid, soft_reset, layer_num);
        end
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        axi_read(5'h1C, d, r);
        tests++;
        if (d !== 32'd1 || r !== 2'b00) begin
            fails++;
            $display("FAIL post_reset_rd got %h/%b required 00000001/00", d, r);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        wv_cnt = 0; bv_cnt = 0; nrd_cnt = 0;
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        result_in = '0; result_valid = 1'b0; neuron_out_data = '0;

        test_reset();
        test_config_write();
        test_stall();
        test_result_irq();
        test_slverr();
        test_neuron_out();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zynet_axil_slave.md
Name: zynet_axil_slave

Overview:
- AXI4-Lite responder and register file sitting in front of the zyNet neural-network core.
- Terminates the PS/bench AXI4-Lite initiator.
- Converts register writes into weight/bias load strobes with layer/neuron select.
- Captures the network result and raises a level interrupt until software reads the result.

Parameters:
- DATA_WIDTH, 16, width of weight/bias/result values (matches `dataWidth).
- ADDR_WIDTH, 5, AXI address width; decode uses addr[4:2].
- NUM_LAYERS, 3, highest legal layer number; layer writes above this return SLVERR.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  / s_axi_awready out 1
- s_axi_wdata  in  32  / s_axi_wstrb in 4 / s_axi_wvalid in 1 / s_axi_wready out 1
- s_axi_bresp  out  2  / s_axi_bvalid out 1 / s_axi_bready in 1
- s_axi_araddr  in  ADDR_WIDTH  / s_axi_arvalid in 1 / s_axi_arready out 1
- s_axi_rdata  out  32  / s_axi_rresp out 2 / s_axi_rvalid out 1 / s_axi_rready in 1
- weight_valid  out  1  one-cycle strobe, weight_value valid
- bias_valid  out  1  one-cycle strobe, weight_value holds bias
- weight_value  out  32  last written weight/bias word
- layer_num  out  32  configured layer
- neuron_num  out  32  configured neuron
- result_in  in  DATA_WIDTH  network output
- result_valid  in  1  one-cycle pulse, result_in valid
- neuron_out_data  in  DATA_WIDTH  per-neuron debug output
- neuron_out_rd  out  1  one-cycle pop when 0x14 is read
- soft_reset  out  1  core soft reset, active-high
- intr  out  1  result-ready interrupt, level

Behaviour:
- Register map (byte offsets):
  - 0x00 weight (WO)
  - 0x04 bias (WO)
  - 0x08 result (RO)
  - 0x0C layer (RW)
  - 0x10 neuron (RW)
  - 0x14 neuron output (RO, pops)
  - 0x18 status (RO: bit0 = intr, bit1 = soft_reset)
  - 0x1C soft reset (RW, bit0)
  - addr[1:0] ignored.
- Reset values: all outputs 0 except soft_reset = 1. Core is held in reset until software writes 0 to 0x1C.
- Write channel: IDLE -> RESP.
  - In IDLE, when awvalid & wvalid are both high, assert awready and wready for exactly one cycle, perform the write on the same edge, and move to RESP.
  - awvalid without wvalid (or the reverse) waits; neither ready is asserted.
  - RESP: bvalid = 1 from the cycle after the handshake, held until bready. Return to IDLE on bvalid & bready. No new write is accepted while bvalid = 1.
- Read channel: IDLE -> DATA.
  - arready is pulsed one cycle on arvalid in IDLE.
  - rdata/rresp are registered; rvalid is high the next cycle and held until rready.
  - rdata stays stable while rvalid & !rready.
- Write effects:
  - 0x00 / 0x04: weight_value <= wdata; weight_valid / bias_valid high for exactly the cycle after the handshake. wstrb ignored (full word).
  - 0x0C / 0x10 / 0x1C: per-byte wstrb merge.
- Responses:
  - bresp = SLVERR (2'b10) for writes to 0x08, 0x14, 0x18, or a layer value of 0 or greater than NUM_LAYERS. The register is left unchanged on SLVERR.
  - Reads of 0x00 / 0x04 return 0 with OKAY. Everything else returns OKAY.
- Result and interrupt:
  - result_valid latches result_in zero-extended and sets intr on the next edge.
  - A completed read handshake of 0x08 (rvalid & rready) clears intr.
  - If result_valid coincides with the clearing handshake, set wins: new result is latched and intr stays 1.
  - A further result_valid while intr = 1 overwrites the result; intr stays 1.
- Neuron output: an accepted read of 0x14 returns neuron_out_data sampled at the arready cycle and pulses neuron_out_rd in that same cycle.
- Reset mid-transaction: async reset drops bvalid/rvalid immediately, returns both FSMs to IDLE and discards the in-flight transfer.

Optional Feature:
- ZYNET_CFG_COUNT_EN defined: 16-bit counter increments on every weight_valid or bias_valid and clears on soft_reset rising. Reads of 0x00 return {16'd0, count}.
- Undefined: no counter; reads of 0x00 return 0.

Decomposition:
- Package zynet_regs_pkg holds:
  - register offsets: ADDR_WEIGHT, ADDR_BIAS, ADDR_RESULT, ADDR_LAYER, ADDR_NEURON, ADDR_NOUT, ADDR_STATUS, ADDR_SRST
  - response codes: RESP_OKAY, RESP_SLVERR
  - FSM state encodings
- One natural sub-module: zynet_axil_irq, which holds the result latch plus intr set/clear priority logic.
- Write and read channels stay in the top module.

Test Plan:
- Reset, then read 0x1C -> rdata = 1, soft_reset = 1, intr = 0. Write 0 to 0x1C -> bresp OKAY, soft_reset = 0.
- Write 0x0C = 2, 0x10 = 5, 0x00 = 0x1234 -> layer_num = 2, neuron_num = 5, weight_value = 0x1234, single-cycle weight_valid, no bias_valid.
- Drive awvalid 3 cycles before wvalid -> no awready until wvalid. Hold bready low 4 cycles -> bvalid held, second write stalls.
- Pulse result_valid with result_in = 0x0001 -> intr = 1 next cycle. Read 0x08 -> rdata = 0x1, intr = 0 after handshake. Coincident result_valid at the handshake -> intr stays 1.
- Write 0x0C = 4 -> SLVERR, layer_num unchanged. Write 0x08 -> SLVERR.
- Assert s_axi_aresetn low while rvalid = 1 with rready low -> rvalid = 0 immediately, soft_reset = 1, next read completes normally.
